// File: rtl/ce_generator_multi.sv
// ce_generator_multi
// Multi-channel clock-enable generator. A free-running master counter feeds
// NUM_CH power-of-two enable channels whose ratio can be changed at run time
// (applied only at a counter wrap), plus one fractional phase-accumulator
// enable for non-power-of-two rates.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   div_sel      requested ratio select per channel, ratio = 2^sel
//   ch_en        per-channel enable; 0 forces that channel's pulses to 0
//   resync       strobe that realigns the master counter to 0
//   frac_inc     fractional increment, f_out = f_clk*frac_inc/2^ACC_W
//   ce_p / ce_n  positive / negative phase single-cycle enables
//   clk_div      50% square wave toggling on each ce_p
//   sel_pending  requested select differs from the active one
//   ce_frac      registered accumulator carry pulse
//   ce_base      master counter is 0
module ce_generator_multi #(
  parameter int CNT_W   = 6,
  parameter int NUM_CH  = 4,
  parameter int SEL_W   = 3,
  parameter int DEF_SEL = 3,
  parameter int ACC_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*SEL_W-1:0]  div_sel,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     resync,
  input  logic [ACC_W-1:0]         frac_inc,
  output logic [NUM_CH-1:0]        ce_p,
  output logic [NUM_CH-1:0]        ce_n,
  output logic [NUM_CH-1:0]        clk_div,
  output logic [NUM_CH-1:0]        sel_pending,
  output logic                     ce_frac,
  output logic                     ce_base
);

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NUM_CH-1:0][SEL_W-1:0] sel_q, sel_d;
  logic [NUM_CH-1:0]            clk_div_q, clk_div_d;
  logic [ACC_W-1:0]             acc_q, acc_d;
  logic                         ce_frac_q, ce_frac_d;
  logic                         wrap;
  logic [ACC_W:0]               acc_sum;

  // Selects beyond the counter range clamp to the largest usable ratio.
  function automatic logic [SEL_W-1:0] sat_sel(input logic [SEL_W-1:0] s);
    if (int'(s) > CNT_W - 1) return SEL_W'(CNT_W - 1);
    return s;
  endfunction

  always_comb begin
    logic [CNT_W-1:0] mask;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] phase;
    logic [SEL_W-1:0] req;

    // Select updates only on the edge that takes cnt to 0, so the first
    // pulse at a new rate lands at cnt = 0 and no runt period appears.
    wrap    = resync || (cnt_q == '1);
    cnt_d   = resync ? '0 : cnt_q + CNT_W'(1);
    ce_p    = '0;
    ce_n    = '0;
    sel_d   = sel_q;
    sel_pending = '0;

    for (int ch = 0; ch < NUM_CH; ch++) begin
      req   = div_sel[ch*SEL_W +: SEL_W];
      mask  = (CNT_W'(1) << sel_q[ch]) - CNT_W'(1);
      half  = (CNT_W'(1) << sel_q[ch]) >> 1;
      phase = cnt_q & mask;
      ce_p[ch] = reset_n && ch_en[ch] && (phase == '0);
      // For sel = 0 half is 0, which would alias ce_p; ce_n stays low there.
      ce_n[ch] = reset_n && ch_en[ch] && (sel_q[ch] != '0) && (phase == half);
      sel_pending[ch] = (req != sel_q[ch]);
      if (wrap) sel_d[ch] = sat_sel(req);
    end

    // clk_div only advances on delivered ce_p, so it freezes while disabled.
    clk_div_d = clk_div_q ^ ce_p;

    acc_sum   = {1'b0, acc_q} + {1'b0, frac_inc};
    acc_d     = acc_sum[ACC_W-1:0];
    ce_frac_d = acc_sum[ACC_W];

    clk_div = clk_div_q & {NUM_CH{reset_n}};
    ce_frac = ce_frac_q & reset_n;
    ce_base = reset_n && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      clk_div_q <= '0;
      acc_q     <= '0;
      ce_frac_q <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sel_q[ch] <= sat_sel(SEL_W'(DEF_SEL));
      end
    end else begin
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      clk_div_q <= clk_div_d;
      acc_q     <= acc_d;
      ce_frac_q <= ce_frac_d;
    end
  end

endmodule

// File: tb/tb_ce_generator_multi.sv
module tb_ce_generator_multi;
  localparam int CNT_W = 6, NUM_CH = 4, SEL_W = 3, DEF_SEL = 3, ACC_W = 16;
  localparam int MOD = 1 << CNT_W;
  localparam int AMOD = 1 << ACC_W;
  localparam logic [11:0] SEL_DEF_ALL = 12'b011_011_011_011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset_n;
  logic [NUM_CH*SEL_W-1:0] div_sel;
  logic [NUM_CH-1:0]       ch_en;
  logic                    resync;
  logic [ACC_W-1:0]        frac_inc;
  logic [NUM_CH-1:0]       ce_p, ce_n, clk_div, sel_pending;
  logic                    ce_frac, ce_base;

  ce_generator_multi #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W),
                       .DEF_SEL(DEF_SEL), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset_n(reset_n), .div_sel(div_sel), .ch_en(ch_en),
    .resync(resync), .frac_inc(frac_inc), .ce_p(ce_p), .ce_n(ce_n),
    .clk_div(clk_div), .sel_pending(sel_pending), .ce_frac(ce_frac),
    .ce_base(ce_base));

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: counter value, active ratio exponents, toggle clocks,
  // accumulator as plain integers.
  int m_cnt;
  int m_sel [NUM_CH];
  bit m_cdiv[NUM_CH];
  int m_acc;
  bit m_cef;
  logic [NUM_CH-1:0] e_ce_p, e_ce_n, e_cdiv, e_pend;
  logic e_frac, e_base;

  function automatic int req_sel(int ch);
    logic [SEL_W-1:0] v;
    v = div_sel[ch*SEL_W +: SEL_W];
    return int'(v);
  endfunction

  function automatic int sat(int s);
    return (s > CNT_W - 1) ? CNT_W - 1 : s;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_acc = 0; m_cef = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_sel[ch] = DEF_SEL; m_cdiv[ch] = 0;
    end
  endtask

  // Compute expected outputs for the current cycle from model + inputs.
  task automatic settle();
    int period, ph;
    #1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      period = 1 << m_sel[ch];
      ph = m_cnt % period;
      e_ce_p[ch] = reset_n && ch_en[ch] && (ph == 0);
      e_ce_n[ch] = reset_n && ch_en[ch] && (m_sel[ch] > 0) && (ph == period / 2);
      e_cdiv[ch] = reset_n && m_cdiv[ch];
      e_pend[ch] = (req_sel(ch) != m_sel[ch]);
    end
    e_base = reset_n && (m_cnt == 0);
    e_frac = reset_n && m_cef;
  endtask

  // Advance the model across one clock edge and wait for the next cycle.
  task automatic tick();
    int sum;
    if (!reset_n) model_reset();
    else begin
      for (int ch = 0; ch < NUM_CH; ch++) if (e_ce_p[ch]) m_cdiv[ch] = !m_cdiv[ch];
      if (resync || m_cnt == MOD - 1)
        for (int ch = 0; ch < NUM_CH; ch++) m_sel[ch] = sat(req_sel(ch));
      m_cnt = resync ? 0 : (m_cnt + 1) % MOD;
      sum = m_acc + int'(frac_inc);
      m_cef = (sum >= AMOD);
      m_acc = sum % AMOD;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      reset_n = 0; div_sel = 12'($urandom); ch_en = 4'($urandom);
      resync = 1'($urandom); frac_inc = 16'($urandom);
      settle();
      total_cnt++;
      if ({ce_p, ce_n, clk_div, ce_frac, ce_base} !== 18'd0)
        $display("FAIL reset_outputs: got %h want 0", {ce_p, ce_n, clk_div, ce_frac, ce_base});
      else pass_cnt++;
      total_cnt++;
      if (i > 0 && sel_pending !== e_pend)
        $display("FAIL reset_pending: got %h want %h", sel_pending, e_pend);
      else pass_cnt++;
      tick();
    end
    reset_n = 1; div_sel = SEL_DEF_ALL; ch_en = '1; resync = 0; frac_inc = '0;
  endtask

  task automatic test_default_rate();
    for (int k = 0; k < 48; k++) begin
      settle();
      total_cnt++;
      if ({ce_p[0], ce_n[0], clk_div[0], ce_base} !==
          {k % 8 == 0, k % 8 == 4, ((k + 7) / 8) % 2 == 1, k % 64 == 0})
        $display("FAIL default_rate k=%0d: got p%b n%b d%b b%b", k, ce_p[0], ce_n[0], clk_div[0], ce_base);
      else pass_cnt++;
      total_cnt++;
      if ({ce_p, ce_n, clk_div, sel_pending, ce_frac, ce_base} !==
          {e_ce_p, e_ce_n, e_cdiv, e_pend, e_frac, e_base})
        $display("FAIL default_model k=%0d: got %h want %h", k,
                 {ce_p, ce_n, clk_div, sel_pending, ce_frac, ce_base},
                 {e_ce_p, e_ce_n, e_cdiv, e_pend, e_frac, e_base});
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic wait_cnt(int target, string name);
    int budget = 2 * MOD;
    settle();
    while (m_cnt != target && budget > 0) begin
      tick(); settle(); budget--;
    end
    total_cnt++;
    if (m_cnt != target) $display("FAIL %s_wait: got cnt %0d want %0d", name, m_cnt, target);
    else pass_cnt++;
  endtask

  task automatic test_ratio_switch();
    bit want_p;
    wait_cnt(10, "switch");
    div_sel[1*SEL_W +: SEL_W] = 3'd1;
    for (int i = 0; i < 70; i++) begin
      settle();
      want_p = (i < 54) ? ((10 + i) % 8 == 0) : ((i - 54) % 2 == 0);
      total_cnt++;
      if ({sel_pending[1], ce_p[1]} !== {i < 54, want_p})
        $display("FAIL ratio_switch i=%0d: got pend%b p%b want pend%b p%b", i, sel_pending[1], ce_p[1], i < 54, want_p);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_sel_extremes();
    div_sel[2*SEL_W +: SEL_W] = 3'd0;
    wait_cnt(0, "sel0");
    for (int k = 0; k < 16; k++) begin
      settle();
      total_cnt++;
      if ({ce_p[2], ce_n[2]} !== 2'b10)
        $display("FAIL sel0 k=%0d: got p%b n%b want p1 n0", k, ce_p[2], ce_n[2]);
      else pass_cnt++;
      tick();
    end
    div_sel[2*SEL_W +: SEL_W] = 3'd5;
    wait_cnt(0, "sel5");
    for (int k = 0; k < 64; k++) begin
      settle();
      total_cnt++;
      if ({ce_p[2], ce_n[2]} !== {k == 0 || k == 32, k == 16 || k == 48})
        $display("FAIL sel5 k=%0d: got p%b n%b", k, ce_p[2], ce_n[2]);
      else pass_cnt++;
      tick();
    end
    div_sel[2*SEL_W +: SEL_W] = 3'd7;
    wait_cnt(0, "sel7");
    for (int k = 0; k < 64; k++) begin
      settle();
      total_cnt++;
      if ({ce_p[2], ce_n[2], sel_pending[2]} !== {k == 0 || k == 32, k == 16 || k == 48, 1'b1})
        $display("FAIL sel_saturate k=%0d: got p%b n%b pend%b", k, ce_p[2], ce_n[2], sel_pending[2]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_resync();
    wait_cnt(30, "resync");
    div_sel[0 +: SEL_W] = 3'd2;
    wait_cnt(37, "resync37");
    total_cnt++;
    if (sel_pending[0] !== 1'b1) $display("FAIL resync_pending_before: got %b want 1", sel_pending[0]);
    else pass_cnt++;
    resync = 1; tick(); resync = 0;
    settle();
    total_cnt++;
    if ({ce_base, ce_p, sel_pending[0]} !== {1'b1, 4'hF, 1'b0})
      $display("FAIL resync_align: got base%b p%h pend%b want base1 pF pend0", ce_base, ce_p, sel_pending[0]);
    else pass_cnt++;
    tick(); settle();
    total_cnt++;
    if ({ce_base, ce_p[0]} !== 2'b00) $display("FAIL resync_next: got base%b p0=%b want 00", ce_base, ce_p[0]);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_ch_en();
    bit frozen;
    settle();
    frozen = m_cdiv[3];
    ch_en[3] = 0;
    for (int k = 0; k < 20; k++) begin
      settle();
      total_cnt++;
      if ({ce_p[3], ce_n[3], clk_div[3]} !== {2'b00, frozen})
        $display("FAIL ch_en_off k=%0d: got p%b n%b d%b want p0 n0 d%b", k, ce_p[3], ce_n[3], clk_div[3], frozen);
      else pass_cnt++;
      tick();
    end
    ch_en[3] = 1;
    for (int k = 0; k < 40; k++) begin
      settle();
      total_cnt++;
      if ({ce_p, ce_n, clk_div} !== {e_ce_p, e_ce_n, e_cdiv})
        $display("FAIL ch_en_resume k=%0d: got %h want %h", k, {ce_p, ce_n, clk_div}, {e_ce_p, e_ce_n, e_cdiv});
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_frac();
    int pulses, win;
    frac_inc = 16'h4000; settle(); tick();
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      settle();
      if (ce_frac === 1'b1) pulses++;
      total_cnt++;
      if (ce_frac !== e_frac) $display("FAIL frac_4000 k=%0d: got %b want %b", k, ce_frac, e_frac);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (pulses != 10) $display("FAIL frac_4000_count: got %0d want 10", pulses);
    else pass_cnt++;
    frac_inc = 16'h5555; settle(); tick();
    pulses = 0; win = 0;
    for (int k = 0; k < 900; k++) begin
      settle();
      if (ce_frac === 1'b1) begin pulses++; win++; end
      if (k % 9 == 8) begin
        total_cnt++;
        if (win < 2 || win > 4) $display("FAIL frac_5555_window k=%0d: got %0d want 2..4", k, win);
        else pass_cnt++;
        win = 0;
      end
      tick();
    end
    total_cnt++;
    if (pulses < 298 || pulses > 301) $display("FAIL frac_5555_count: got %0d want 298..301", pulses);
    else pass_cnt++;
    frac_inc = '0;
  endtask

  task automatic test_reset_mid();
    reset_n = 0; settle();
    total_cnt++;
    if ({ce_p, ce_n, clk_div, ce_frac, ce_base} !== 18'd0)
      $display("FAIL reset_mid_outputs: got %h want 0", {ce_p, ce_n, clk_div, ce_frac, ce_base});
    else pass_cnt++;
    tick();
    reset_n = 1; settle();
    total_cnt++;
    if ({ce_base, ce_p, clk_div} !== {1'b1, 4'hF, 4'h0})
      $display("FAIL reset_mid_restart: got base%b p%h d%h want base1 pF d0", ce_base, ce_p, clk_div);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      resync = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) div_sel = 12'($urandom);
      if ($urandom_range(0, 9) == 0) ch_en = 4'($urandom);
      if ($urandom_range(0, 99) == 0) frac_inc = 16'($urandom);
      settle();
      total_cnt++;
      if ({ce_p, ce_n, clk_div, sel_pending, ce_frac, ce_base} !==
          {e_ce_p, e_ce_n, e_cdiv, e_pend, e_frac, e_base})
        $display("FAIL random k=%0d: got %h want %h", k,
                 {ce_p, ce_n, clk_div, sel_pending, ce_frac, ce_base},
                 {e_ce_p, e_ce_n, e_cdiv, e_pend, e_frac, e_base});
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    reset_n = 0; div_sel = SEL_DEF_ALL; ch_en = '1; resync = 0; frac_inc = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_default_rate();
    test_ratio_switch();
    test_sel_extremes();
    test_resync();
    test_ch_en();
    test_frac();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
